// File: rtl/dtree_seq_walker.sv
// Sequential decision-tree walker: one shared comparator, one node per FETCH/EVAL pair.
// Optional DTREE_SEQ_WDOG_EN adds a visit-count watchdog that aborts runaway walks.
module dtree_seq_walker #(
  parameter int NFEAT = 6,
  parameter int FW    = 8,
  parameter int CW    = 2,
  parameter int AW    = 6,
  parameter int MAXN  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NFEAT*FW-1:0] x_flat,
  output logic                node_rd,
  output logic [AW-1:0]       node_addr,
  input  logic                nd_leaf,
  input  logic [2:0]          nd_feat,
  input  logic [2:0]          nd_shift,
  input  logic [FW-1:0]       nd_thr,
  input  logic [AW-1:0]       nd_left,
  input  logic [AW-1:0]       nd_right,
  input  logic [CW-1:0]       nd_class,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_class,
  output logic                out_err
);

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  state_t                    r_state, w_state_nx;
  logic [NFEAT-1:0][FW-1:0]  r_x;
  logic [AW-1:0]             r_addr, w_addr_nx;
  logic [CW-1:0]             r_class, w_class_nx;
  logic                      r_err, w_err_nx;
  logic                      r_in_ready;
  logic                      w_accept;
  logic                      w_vis_inc;
  logic                      w_wdog_trip;
  logic                      w_feat_bad;
  logic                      w_le;
  logic [FW-1:0]             w_feat;

  assign w_accept   = in_valid && r_in_ready;
  assign w_feat_bad = 32'(nd_feat) >= NFEAT;

  always_comb begin
    w_feat = '0;
    for (int i = 0; i < NFEAT; i++)
      if (nd_feat == 3'(i)) w_feat = r_x[i];
  end

  // Zero-fill shift keeps the compare unsigned at full FW width.
  assign w_le = (w_feat >> nd_shift) <= nd_thr;

`ifdef DTREE_SEQ_WDOG_EN
  localparam int VW = $clog2(MAXN + 1);
  logic [VW-1:0] r_visits;

  // The MAXN-th internal evaluation is the last one allowed; it aborts instead of fetching again.
  assign w_wdog_trip = (r_visits == VW'(MAXN - 1));

  always_ff @(posedge clk) begin
    if (rst || w_accept) r_visits <= '0;
    else if (w_vis_inc)  r_visits <= r_visits + 1'b1;
  end
`else
  assign w_wdog_trip = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_class_nx = r_class;
    w_err_nx   = r_err;
    w_vis_inc  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nx = FETCH;
          w_addr_nx  = '0;
        end
      end
      FETCH: w_state_nx = EVAL;
      EVAL: begin
        if (nd_leaf) begin
          w_class_nx = nd_class;
          w_err_nx   = 1'b0;
          w_state_nx = DONE;
        end else if (w_feat_bad || w_wdog_trip) begin
          w_class_nx = '0;
          w_err_nx   = 1'b1;
          w_state_nx = DONE;
        end else begin
          w_addr_nx  = w_le ? nd_left : nd_right;
          w_vis_inc  = 1'b1;
          w_state_nx = FETCH;
        end
      end
      DONE: if (out_ready) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_class    <= '0;
      r_err      <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_addr     <= w_addr_nx;
      r_class    <= w_class_nx;
      r_err      <= w_err_nx;
      r_in_ready <= (w_state_nx == IDLE);
    end
  end

  // Features are captured only at acceptance, so later x_flat changes are invisible.
  always_ff @(posedge clk) begin
    if (w_accept) r_x <= x_flat;
  end

  assign in_ready  = r_in_ready;
  assign node_rd   = (r_state == FETCH);
  assign node_addr = r_addr;
  assign out_valid = (r_state == DONE);
  assign out_class = r_class;
  assign out_err   = r_err;

endmodule
